// File: rtl/axi4_lite_reg_slave.sv
// rtl/axi4_lite_reg_slave.sv - AXI4-Lite register bank responder with byte strobes
// Optional build macro AXI4_LITE_REG_SLVERR_EN: bad addresses answer SLVERR instead of OKAY.
module axi4_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4_LITE_REG_SLVERR_EN
    localparam logic [1:0] RESP_BAD = 2'b10;
`else
    localparam logic [1:0] RESP_BAD = 2'b00;
`endif
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_held, w_held, aw_ok;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic aw_fire, w_fire, ar_fire, b_fire, r_fire, commit;
    logic aw_held_n, w_held_n, bvalid_n, rvalid_n;
    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic aw_addr_ok, ar_addr_ok;

    // Offsets wrap modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR decode as out of range.
    assign aw_off     = awaddr - BASE_ADDR;
    assign ar_off     = araddr - BASE_ADDR;
    assign aw_addr_ok = (aw_off < SPAN) && (aw_off[1:0] == 2'b00);
    assign ar_addr_ok = (ar_off < SPAN) && (ar_off[1:0] == 2'b00);

    always_comb begin
        aw_fire   = awready && awvalid;
        w_fire    = wready && wvalid;
        ar_fire   = arready && arvalid;
        b_fire    = bvalid && bready;
        r_fire    = rvalid && rready;
        commit    = aw_held && w_held && !bvalid;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        bvalid_n  = bvalid;
        rvalid_n  = rvalid;
        if (aw_fire) aw_held_n = 1'b1;
        if (w_fire)  w_held_n  = 1'b1;
        if (commit) begin
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b1;
        end else if (b_fire) begin
            bvalid_n = 1'b0;
        end
        if (ar_fire)     rvalid_n = 1'b1;
        else if (r_fire) rvalid_n = 1'b0;
    end

    // Ready outputs are registered copies of the next-state holding conditions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_ok    <= 1'b0;
            aw_idx   <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            arready  <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
            reg_wr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            bvalid  <= bvalid_n;
            rvalid  <= rvalid_n;
            awready <= !aw_held_n && !bvalid_n;
            wready  <= !w_held_n && !bvalid_n;
            arready <= !rvalid_n;
            reg_wr  <= '0;
            if (aw_fire) begin
                aw_ok  <= aw_addr_ok;
                aw_idx <= aw_off[2 +: IDX_W];
            end
            if (w_fire) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                bresp <= aw_ok ? RESP_OKAY : RESP_BAD;
                if (aw_ok) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) regs[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                    reg_wr <= NUM_REGS'(1) << aw_idx;
                end
            end
            // Nonblocking read of regs returns the pre-commit value on a same-edge collision.
            if (ar_fire) begin
                rresp <= ar_addr_ok ? RESP_OKAY : RESP_BAD;
                rdata <= ar_addr_ok ? regs[ar_off[2 +: IDX_W]] : '0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb/tb_axi4_lite_reg_slave.sv - scoreboard bench for axi4_lite_reg_slave
`timescale 1ns/1ps
module tb_axi4_lite_reg_slave;
    localparam int          NR   = 16;
    localparam int          FW   = NR * 32;
    localparam logic [31:0] BASE = 32'h0;
    localparam int          TMO  = 50;
`ifdef AXI4_LITE_REG_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;
    logic [FW-1:0] reg_q;
    logic [NR-1:0] reg_wr;

    always #5 clk = ~clk;

    axi4_lite_reg_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q), .reg_wr(reg_wr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0]   model [NR];
    logic [1:0]    b_exp_q  [$];
    logic [33:0]   r_exp_q  [$];
    logic [NR-1:0] wr_exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm, input string got, input string want);
        total++;
        bad++;
        $display("FAIL %s: got %s want %s", nm, got, want);
    endtask

    function automatic bit m_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'(4 * NR)) && (off % 4 == 0);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [FW-1:0] m_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // Monitor: every presented response is checked against the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (bvalid) begin
                if (b_exp_q.size() == 0) fail_evt("b_unexpected", "bvalid=1", "no response");
                else begin
                    chk("bresp", FW'(bresp), FW'(b_exp_q[0]));
                    if (bready) void'(b_exp_q.pop_front());
                end
            end
            if (rvalid) begin
                if (r_exp_q.size() == 0) fail_evt("r_unexpected", "rvalid=1", "no response");
                else begin
                    chk("rdata", FW'(rdata), FW'(r_exp_q[0][31:0]));
                    chk("rresp", FW'(rresp), FW'(r_exp_q[0][33:32]));
                    if (rready) void'(r_exp_q.pop_front());
                end
            end
            if (reg_wr != '0) begin
                if (wr_exp_q.size() == 0) fail_evt("reg_wr_unexpected", $sformatf("%0h", reg_wr), "0");
                else chk("reg_wr", FW'(reg_wr), FW'(wr_exp_q.pop_front()));
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int  t0, lat, n, idx;
        bit  ok;
        @(posedge clk); #1;
        ok  = m_ok(addr);
        idx = m_idx(addr);
        b_exp_q.push_back(ok ? 2'b00 : ERR_RESP);
        if (ok) wr_exp_q.push_back(NR'(1) << idx);
        t0  = cyc;
        lat = -1;
        fork
            begin
                int k = 0;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr = addr; awvalid = 1'b1;
                do begin @(negedge clk); k++; end while (!awready && k < TMO);
                if (!awready) fail_evt("aw_timeout", "awready=0", "awready=1");
                @(posedge clk); #1; awvalid = 1'b0;
            end
            begin
                int k = 0;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata = data; wstrb = strb; wvalid = 1'b1;
                do begin @(negedge clk); k++; end while (!wready && k < TMO);
                if (!wready) fail_evt("w_timeout", "wready=0", "wready=1");
                @(posedge clk); #1; wvalid = 1'b0;
            end
        join
        repeat (b_dly) begin @(posedge clk); #1; end
        bready = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (bvalid && lat < 0) lat = cyc - t0;
        end while (!bvalid && n < TMO);
        if (!bvalid) fail_evt("b_timeout", "bvalid=0", "bvalid=1");
        if (aw_dly == 0 && w_dly == 0 && b_dly == 0) chk("b_latency", FW'(lat), FW'(2));
        @(posedge clk); #1; bready = 1'b0;
        if (ok) for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        chk("reg_q_after_write", reg_q, m_flat());
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        int n;
        @(posedge clk); #1;
        r_exp_q.push_back(m_ok(addr) ? {2'b00, model[m_idx(addr)]} : {ERR_RESP, 32'h0});
        repeat (ar_dly) begin @(posedge clk); #1; end
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < TMO);
        if (!arready) fail_evt("ar_timeout", "arready=0", "arready=1");
        @(posedge clk); #1; arvalid = 1'b0;
        @(negedge clk);
        chk("r_latency_rvalid", FW'(rvalid), FW'(1));
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); @(negedge clk);
            chk("arready_while_rvalid", FW'(arready), FW'(0));
        end
        @(posedge clk); #1; rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < TMO);
        if (!rvalid) fail_evt("r_timeout", "rvalid=0", "rvalid=1");
        @(posedge clk); #1; rready = 1'b0;
        @(negedge clk);
        chk("arready_after_r", FW'(arready), FW'(1));
    endtask

    initial begin
        rst = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", FW'(awready), FW'(0));
        chk("rst_arready", FW'(arready), FW'(0));
        chk("rst_bvalid", FW'(bvalid), FW'(0));
        chk("rst_rvalid", FW'(rvalid), FW'(0));
        chk("rst_rdata", FW'(rdata), FW'(0));
        chk("rst_reg_q", reg_q, '0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_ready", FW'({awready, wready, arready}), FW'(3'b111));

        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg2_value", FW'(reg_q[95:64]), FW'(32'hDEADBEEF));

        do_write(32'h0C, 32'hAABBCCDD, 4'hF, 1, 2, 0);
        fork
            do_write(32'h0C, 32'h11223344, 4'b0101, 3, 0, 0);
            begin
                @(posedge clk); @(negedge clk);
                repeat (4) begin
                    @(negedge clk);
                    chk("wready_held_low", FW'(wready), FW'(0));
                end
            end
        join
        chk("reg3_value", FW'(reg_q[127:96]), FW'(32'hAA22CC44));

        do_read(32'h08, 0, 5);

        do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
        do_read(32'h06, 0, 0);

        fork
            do_write(32'h04, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
            begin
                @(posedge clk); #1;
                do_read(32'h04, 0, 0);
            end
        join
        do_read(32'h04, 0, 0);

        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'(4 * $urandom_range(0, NR - 1));
            else if (sel == 7) a = 32'(4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
            else if (sel == 8) a = 32'(4 * NR + 4 * $urandom_range(0, 100));
            else               a = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while a write response is stalled.
        @(posedge clk); #1;
        b_exp_q.push_back(2'b00);
        wr_exp_q.push_back(NR'(1) << 5);
        awaddr = 32'h14; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!bvalid && n < TMO);
            if (!bvalid) fail_evt("rst_test_b_timeout", "bvalid=0", "bvalid=1");
        end
        #2 rst = 1'b0;
        #1;
        chk("rst_async_bvalid", FW'(bvalid), FW'(0));
        chk("rst_async_reg_q", reg_q, '0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        b_exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_release_ready", FW'({awready, wready, arready}), FW'(3'b111));
        repeat (5) @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk("rst_release_reg_q", reg_q, m_flat());

        chk("b_queue_drained", FW'(b_exp_q.size()), FW'(0));
        chk("r_queue_drained", FW'(r_exp_q.size()), FW'(0));
        chk("wr_queue_drained", FW'(wr_exp_q.size()), FW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        fail_evt("global_timeout", "running", "finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
